vga_score_render: RTL

//  Parametrised seven-segment score renderer for the VGA path, generalising the single-digit pixel generator.

---
 rtl/vga_score_render.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/vga_score_render.sv
// Seven-segment score renderer: draws NUM_DIGITS BCD digits into the VGA pixel stream
// with frame-synchronous score updates, optional leading-zero blanking and blink.
module vga_score_render #(
    parameter int unsigned NUM_DIGITS   = 2,
    parameter int unsigned X0           = 280,
    parameter int unsigned Y0           = 190,
    parameter int unsigned SEG_T        = 10,
    parameter int unsigned SEG_L        = 30,
    parameter int unsigned DIGIT_GAP    = 20,
    parameter logic [11:0] FG_COLOR     = 12'hfff,
    parameter logic [11:0] BG_COLOR     = 12'h000,
    parameter bit          LZ_BLANK     = 1'b1,
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [9:0]              h_cnt,
    input  logic [9:0]              v_cnt,
    input  logic                    valid,
    input  logic                    vsync,
    input  logic [4*NUM_DIGITS-1:0] score_in,
    input  logic                    score_load,
    input  logic                    blink_en,
    output logic [3:0]              vgaRed,
    output logic [3:0]              vgaGreen,
    output logic [3:0]              vgaBlue
);

    localparam int unsigned SW       = 4 * NUM_DIGITS;
    localparam int unsigned CW       = 16;
    localparam int unsigned W        = 2 * SEG_T + SEG_L;
    localparam int unsigned H        = 3 * SEG_T + 2 * SEG_L;
    localparam int unsigned PITCH    = W + DIGIT_GAP;
    localparam int unsigned BW       = (2 * BLINK_FRAMES > 1) ? $clog2(2 * BLINK_FRAMES) : 1;
    localparam int unsigned CNT_LAST = 2 * BLINK_FRAMES - 1;

    localparam logic [CW-1:0] T_C     = CW'(SEG_T);
    localparam logic [CW-1:0] W_C     = CW'(W);
    localparam logic [CW-1:0] Y0_C    = CW'(Y0);
    localparam logic [CW-1:0] YEND_C  = CW'(Y0 + H);
    localparam logic [CW-1:0] MID_LO  = CW'(SEG_T + SEG_L);
    localparam logic [CW-1:0] MID_HI  = CW'(2 * SEG_T + SEG_L);
    localparam logic [CW-1:0] BOT_LO  = CW'(2 * SEG_T + 2 * SEG_L);
    localparam logic [CW-1:0] RIGHT_C = CW'(W - SEG_T);

    logic          vsync_q;
    logic [SW-1:0] shadow_q, shadow_d;
    logic [SW-1:0] shown_q, shown_d;
    logic [BW-1:0] blink_q, blink_d;
    logic [11:0]   rgb_q, rgb_d;
    logic          fe;
    logic          lit;
    logic          hidden;

    // Segment pattern {a,b,c,d,e,f,g}; non-decimal nibbles are blank.
    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'd0:    decode = 7'b1111110;
            4'd1:    decode = 7'b0110000;
            4'd2:    decode = 7'b1101101;
            4'd3:    decode = 7'b1111001;
            4'd4:    decode = 7'b0110011;
            4'd5:    decode = 7'b1011011;
            4'd6:    decode = 7'b1011111;
            4'd7:    decode = 7'b1110000;
            4'd8:    decode = 7'b1111111;
            4'd9:    decode = 7'b1111011;
            default: decode = 7'b0000000;
        endcase
    endfunction

    function automatic logic seg_hit(input logic [6:0] s, input logic [CW-1:0] rx,
                                     input logic [CW-1:0] ry);
        logic top, mid, bot, upper, lower, left, right;
        top   = ry < T_C;
        mid   = (ry >= MID_LO) && (ry < MID_HI);
        bot   = ry >= BOT_LO;
        upper = ry < MID_HI;
        lower = ry >= MID_LO;
        left  = rx < T_C;
        right = rx >= RIGHT_C;
        seg_hit = (s[6] & top) | (s[5] & right & upper) | (s[4] & right & lower) |
                  (s[3] & bot) | (s[2] & left & lower)  | (s[1] & left & upper)  |
                  (s[0] & mid);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_q  <= 1'b1;
            shadow_q <= '0;
            shown_q  <= '0;
            blink_q  <= '0;
            rgb_q    <= '0;
        end else begin
            vsync_q  <= vsync;
            shadow_q <= shadow_d;
            shown_q  <= shown_d;
            blink_q  <= blink_d;
            rgb_q    <= rgb_d;
        end
    end

    // Score/blink state advances only on the falling edge of vsync.
    always_comb begin
        fe       = vsync_q & ~vsync;
        shadow_d = score_load ? score_in : shadow_q;
        shown_d  = fe ? shadow_q : shown_q;
        blink_d  = blink_q;
        if (!blink_en) begin
            blink_d = '0;
        end else if (fe) begin
            blink_d = (blink_q == BW'(CNT_LAST)) ? '0 : blink_q + BW'(1);
        end
    end

    // Pixel hit test across all digit boxes, MS digit first so leading zeros can be tracked.
    always_comb begin
        logic [CW-1:0] hx, vy, ry, rx, xs;
        logic          in_rows, all_zero, blank;
        logic [3:0]    digit;
        hx       = CW'(h_cnt);
        vy       = CW'(v_cnt);
        ry       = vy - Y0_C;
        in_rows  = (vy >= Y0_C) && (vy < YEND_C);
        all_zero = LZ_BLANK;
        lit      = 1'b0;
        rx       = '0;
        xs       = '0;
        blank    = 1'b0;
        digit    = '0;
        for (int k = 0; k < int'(NUM_DIGITS); k++) begin
            digit    = shown_q[4*(int'(NUM_DIGITS)-1-k) +: 4];
            all_zero = all_zero && (digit == 4'd0);
            blank    = all_zero && (k != int'(NUM_DIGITS) - 1);
            xs       = CW'(X0 + PITCH * 32'(k));
            rx       = hx - xs;
            if (in_rows && (hx >= xs) && (hx < xs + W_C) && !blank) begin
                lit = lit | seg_hit(decode(digit), rx, ry);
            end
        end
        hidden = blink_en && (blink_q >= BW'(BLINK_FRAMES));
        if (!valid) begin
            rgb_d = 12'h000;
        end else if (lit && !hidden) begin
            rgb_d = FG_COLOR;
        end else begin
            rgb_d = BG_COLOR;
        end
    end

    assign vgaRed   = rgb_q[11:8];
    assign vgaGreen = rgb_q[7:4];
    assign vgaBlue  = rgb_q[3:0];

endmodule
